neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_sequencer_pkg.sv | 19 +
 rtl/neuron_sequencer_tap_store.sv | 53 +++++
 rtl/neuron_sequencer.sv | 116 +++++++++++
 tb/tb_neuron_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_sequencer_pkg.sv
// Shared defaults and FSM encoding for the neuron sequencer and its tap store.
package neuron_sequencer_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_N_TAPS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    READ   = 2'd3
  } state_t;

  // Tap index width; a single-tap neuron still gets a 1-bit address.
  function automatic int addr_width(input int n_taps);
    return (n_taps > 1) ? $clog2(n_taps) : 1;
  endfunction

endpackage

// File: rtl/neuron_sequencer_tap_store.sv
// N_TAPS x (weight, activation) register file: one write port, one
// combinational read port indexed by the sequencer's tap counter.
module neuron_sequencer_tap_store
  import neuron_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int N_TAPS = DEFAULT_N_TAPS,
  parameter int AW     = addr_width(N_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wweight,
  input  logic [WIDTH-1:0] win,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rweight,
  output logic [WIDTH-1:0] rin
);

  logic [WIDTH-1:0] weight_arr [N_TAPS];
  logic [WIDTH-1:0] in_arr     [N_TAPS];

  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
    logic [WIDTH-1:0] weight_reg;
    logic [WIDTH-1:0] in_reg;

    // Per-tap register; addresses that match no tap are silently dropped.
    always_ff @(posedge clk) begin
      if (reset) begin
        weight_reg <= '0;
        in_reg     <= '0;
      end else if (we && (waddr == AW'(gi))) begin
        weight_reg <= wweight;
        in_reg     <= win;
      end
    end

    assign weight_arr[gi] = weight_reg;
    assign in_arr[gi]     = in_reg;
  end

  // Read mux; guards the unused codes when N_TAPS is not a power of two.
  always_comb begin
    rweight = '0;
    rin     = '0;
    if (int'(raddr) < N_TAPS) begin
      rweight = weight_arr[raddr];
      rin     = in_arr[raddr];
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Streams stored weight/activation pairs into an external MAC, lets the MAC
// pipeline drain, then captures the post-ReLU accumulator as the neuron output.
module neuron_sequencer
  import neuron_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int N_TAPS = DEFAULT_N_TAPS,
  localparam int AW    = addr_width(N_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_weight,
  input  logic [WIDTH-1:0] load_in,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] mac_weight,
  output logic [WIDTH-1:0] mac_in,
  output logic             mac_forget,
  output logic             mac_oe,
  input  logic [WIDTH-1:0] mac_out,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] result_reg;
  logic             result_valid_reg;
  logic [WIDTH-1:0] tap_weight, tap_in;
  logic             store_we;

  // The tap store is frozen while an evaluation is in flight.
  assign store_we = load_we && (state_reg == IDLE);

  neuron_sequencer_tap_store #(
    .WIDTH  (WIDTH),
    .N_TAPS (N_TAPS),
    .AW     (AW)
  ) u_tap_store (
    .clk     (clk),
    .reset   (reset),
    .we      (store_we),
    .waddr   (load_addr),
    .wweight (load_weight),
    .win     (load_in),
    .raddr   (cnt_reg),
    .rweight (tap_weight),
    .rin     (tap_in)
  );

  // Next-state and MAC drive. The MAC registers its product one cycle before
  // accumulating, so forget lines up with the cycle after tap 0 is presented.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mac_weight = '0;
    mac_in     = '0;
    mac_forget = 1'b0;
    mac_oe     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
          cnt_next   = '0;
        end
      end
      STREAM: begin
        mac_weight = tap_weight;
        mac_in     = tap_in;
        mac_forget = (N_TAPS > 1) && (cnt_reg == ONE);
        if (cnt_reg == LAST_TAP) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      DRAIN: begin
        mac_forget = (N_TAPS == 1);
        state_next = READ;
      end
      READ: begin
        mac_oe     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, tap counter and result capture; reset aborts any evaluation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      result_valid_reg <= (state_reg == READ);
      if (state_reg == READ) begin
        result_reg <= mac_out;
      end
    end
  end

  assign busy         = (state_reg != IDLE);
  assign result       = result_reg;
  assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench: a 4-tap and a 1-tap sequencer, each feeding a behavioral
// MAC (registered product, accumulate/forget, ReLU output gated by oe).
module tb_neuron_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- 4-tap instance ----------------
  logic       we4, start4, busy4, mf4, moe4, rv4;
  logic [1:0] addr4;
  logic [7:0] lw4, li4, mw4, mi4, mo4, res4;

  neuron_sequencer #(.WIDTH(8), .N_TAPS(4)) dut4 (
    .clk(clk), .reset(reset), .load_we(we4), .load_addr(addr4),
    .load_weight(lw4), .load_in(li4), .start(start4), .busy(busy4),
    .mac_weight(mw4), .mac_in(mi4), .mac_forget(mf4), .mac_oe(moe4),
    .mac_out(mo4), .result(res4), .result_valid(rv4)
  );

  logic signed [7:0]  prod4, acc4;
  logic signed [15:0] full4;
  assign full4 = $signed(mw4) * $signed(mi4);
  always_ff @(posedge clk) begin
    if (reset) begin
      prod4 <= '0;
      acc4  <= '0;
    end else begin
      prod4 <= full4[7:0];
      acc4  <= mf4 ? prod4 : acc4 + prod4;
    end
  end
  assign mo4 = (moe4 && !acc4[7]) ? acc4 : 8'd0;

  // ---------------- 1-tap instance ----------------
  logic       we1, start1, busy1, mf1, moe1, rv1;
  logic [0:0] addr1;
  logic [7:0] lw1, li1, mw1, mi1, mo1, res1;

  neuron_sequencer #(.WIDTH(8), .N_TAPS(1)) dut1 (
    .clk(clk), .reset(reset), .load_we(we1), .load_addr(addr1),
    .load_weight(lw1), .load_in(li1), .start(start1), .busy(busy1),
    .mac_weight(mw1), .mac_in(mi1), .mac_forget(mf1), .mac_oe(moe1),
    .mac_out(mo1), .result(res1), .result_valid(rv1)
  );

  logic signed [7:0]  prod1, acc1;
  logic signed [15:0] full1;
  assign full1 = $signed(mw1) * $signed(mi1);
  always_ff @(posedge clk) begin
    if (reset) begin
      prod1 <= '0;
      acc1  <= '0;
    end else begin
      prod1 <= full1[7:0];
      acc1  <= mf1 ? prod1 : acc1 + prod1;
    end
  end
  assign mo1 = (moe1 && !acc1[7]) ? acc1 : 8'd0;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [1:0] a, input logic [7:0] w, input logic [7:0] x);
    we4 = 1'b1; addr4 = a; lw4 = w; li4 = x;
    step();
    we4 = 1'b0;
  endtask

  task automatic load1(input logic [0:0] a, input logic [7:0] w, input logic [7:0] x);
    we1 = 1'b1; addr1 = a; lw1 = w; li1 = x;
    step();
    we1 = 1'b0;
  endtask

  // Pulses start, then returns the cycle number (start edge -> cycle 1) in
  // which result_valid is seen; 20 means it never came.
  task automatic run4(output int cyc);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    cyc = 1;
    while (!rv4 && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic run1(output int cyc);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    cyc = 1;
    while (!rv1 && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  int cyc;
  int seen;

  initial begin
    reset = 1'b1;
    we4 = 0; addr4 = 0; lw4 = 0; li4 = 0; start4 = 0;
    we1 = 0; addr1 = 0; lw1 = 0; li1 = 0; start1 = 0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_busy", busy4, 0);
    check("rst_valid", rv4, 0);
    check("rst_result", res4, 0);
    check("rst_mac_weight", mw4, 0);
    check("rst_mac_oe", moe4, 0);
    check("rst_mac_forget", mf4, 0);
    $display("txn reset: busy=%0d valid=%0d result=%0d", busy4, rv4, res4);

    // Test 1: w={1,2,3,4}, in={1,1,1,1}, cycle by cycle
    for (int i = 0; i < 4; i++) load4(2'(i), 8'(i + 1), 8'd1);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("t1_stream_weight", mw4, c);
      check("t1_stream_in", mi4, 1);
      check("t1_stream_forget", mf4, (c == 2) ? 1 : 0);
      check("t1_stream_busy", busy4, 1);
      check("t1_stream_oe", moe4, 0);
      step();
    end
    check("t1_drain_weight", mw4, 0);
    check("t1_drain_in", mi4, 0);
    check("t1_drain_forget", mf4, 0);
    check("t1_drain_busy", busy4, 1);
    step();
    check("t1_read_oe", moe4, 1);
    check("t1_read_busy", busy4, 1);
    check("t1_read_valid", rv4, 0);
    step();
    check("t1_valid_c7", rv4, 1);
    check("t1_result", res4, 10);
    check("t1_valid_busy", busy4, 0);
    $display("txn t1: result=%0d valid=%0d", res4, rv4);
    step();
    check("t1_valid_pulse", rv4, 0);
    check("t1_result_hold", res4, 10);

    // Test 2: ReLU of -9
    load4(2'd0, 8'hFE, 8'd2);
    load4(2'd1, 8'hFD, 8'd2);
    load4(2'd2, 8'd1, 8'd1);
    load4(2'd3, 8'd0, 8'd5);
    run4(cyc);
    check("t2_latency", cyc, 7);
    check("t2_result", res4, 0);
    $display("txn t2: cycle=%0d result=%0d", cyc, res4);

    // Test 3: back-to-back
    for (int i = 0; i < 4; i++) load4(2'(i), 8'(i + 1), 8'd2);
    run4(cyc);
    check("t3a_latency", cyc, 7);
    check("t3a_result", res4, 20);
    $display("txn t3a: cycle=%0d result=%0d", cyc, res4);
    run4(cyc);
    check("t3b_latency", cyc, 7);
    check("t3b_result", res4, 20);
    $display("txn t3b: cycle=%0d result=%0d", cyc, res4);
    step();

    // Test 4: start and load pulsed while busy are ignored
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    start4 = 1'b1; we4 = 1'b1; addr4 = 2'd0; lw4 = 8'd100; li4 = 8'd100;
    step();
    step();
    start4 = 1'b0; we4 = 1'b0;
    cyc = 4;
    while (!rv4 && cyc < 20) begin
      step();
      cyc++;
    end
    check("t4_latency", cyc, 7);
    check("t4_result", res4, 20);
    step();
    check("t4_no_restart", busy4, 0);
    check("t4_no_second_valid", rv4, 0);
    run4(cyc);
    check("t4_store_unchanged", res4, 20);
    $display("txn t4: cycle=%0d result=%0d", cyc, res4);
    step();

    // Test 5: reset in STREAM k=2
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    step();
    check("t5_at_k2_weight", mw4, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_busy", busy4, 0);
    check("t5_mac_weight", mw4, 0);
    check("t5_mac_in", mi4, 0);
    check("t5_mac_forget", mf4, 0);
    check("t5_mac_oe", moe4, 0);
    check("t5_valid", rv4, 0);
    check("t5_result", res4, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rv4) seen++;
    end
    check("t5_no_valid", seen, 0);
    load4(2'd0, 8'd7, 8'd2);
    run4(cyc);
    check("t5_new_latency", cyc, 7);
    check("t5_new_result", res4, 14);
    $display("txn t5: cycle=%0d result=%0d", cyc, res4);

    // Test 6: one tap, load together with start
    load1(1'b0, 8'd2, 8'd2);
    we1 = 1'b1; addr1 = 1'b0; lw1 = 8'd5; li1 = 8'd3; start1 = 1'b1;
    step();
    we1 = 1'b0; start1 = 1'b0;
    check("t6_stream_weight", mw1, 5);
    check("t6_stream_in", mi1, 3);
    check("t6_stream_forget", mf1, 0);
    step();
    check("t6_drain_forget", mf1, 1);
    check("t6_drain_weight", mw1, 0);
    step();
    check("t6_read_oe", moe1, 1);
    step();
    check("t6_valid_c4", rv1, 1);
    check("t6_result", res1, 15);
    $display("txn t6: result=%0d valid=%0d", res1, rv1);

    // Test 7: out-of-range tap address ignored
    load1(1'b1, 8'd9, 8'd9);
    run1(cyc);
    check("t7_latency", cyc, 4);
    check("t7_result", res1, 15);
    $display("txn t7: cycle=%0d result=%0d", cyc, res1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
